// File: rtl/ad9914_pport_wr.sv
`default_nettype none
// ============================================================================
// Module  : ad9914_pport_wr
// Brief   : Byte-serial AD9914 parallel-port writer with IO_UPDATE pulse and
//           optional readback compare.
// Revision: 1.0 - initial release
// ============================================================================
module ad9914_pport_wr #(
  parameter int SETUP_CYC    = 2,
  parameter int WR_PULSE_CYC = 3,
  parameter int RD_PULSE_CYC = 4,
  parameter int HOLD_CYC     = 2,
  parameter int IOUP_CYC     = 4,
  parameter bit VERIFY_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  reg_base_addr,
  input  logic [31:0] reg_wvar,
  input  logic [3:0]  reg_byte_num,
  output logic [31:0] reg_rvar,
  output logic        res,
  output logic        busy,
  output logic        finish,
  output logic        io_update,
  output logic        p_pwd,
  output logic        p_wr,
  output logic        p_rd,
  output logic [7:0]  p_addr,
  output logic [7:0]  p_wdata,
  input  logic [7:0]  p_rdata,
  output logic        data_tri_select
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_STROBE = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_IOUP     = 3'd4,
    ST_R_SETUP  = 3'd5,
    ST_R_STROBE = 3'd6,
    ST_R_HOLD   = 3'd7
  } state_t;

  // Counters are loaded with (length - 1) so each phase lasts exactly its length.
  localparam logic [7:0] c_setup = 8'(SETUP_CYC - 1);
  localparam logic [7:0] c_wr    = 8'(WR_PULSE_CYC - 1);
  localparam logic [7:0] c_rd    = 8'(RD_PULSE_CYC - 1);
  localparam logic [7:0] c_hold  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] c_ioup  = 8'(IOUP_CYC - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_idx;
  logic [1:0]  r_last;
  logic [7:0]  r_base;
  logic [31:0] r_wvar;
  logic [31:0] r_reg_rvar;
  logic        r_res;
  logic        r_busy;
  logic        r_io_update;
  logic        r_p_wr;
  logic        r_p_rd;
  logic [7:0]  r_p_addr;
  logic [7:0]  r_p_wdata;
  logic        r_tri;

  logic        w_cnt_done;
  logic        w_is_last;
  logic [1:0]  w_next_idx;
  logic [7:0]  w_cur_byte;
  logic [7:0]  w_next_byte;
  logic [7:0]  w_req_base;
  logic [1:0]  w_req_last;
  logic        w_unused_base;

  assign w_cnt_done    = (r_cnt == 8'd0);
  assign w_is_last     = (r_idx == r_last);
  assign w_next_idx    = r_idx + 2'd1;
  assign w_cur_byte    = r_wvar[{r_idx, 3'b000} +: 8];
  assign w_next_byte   = r_wvar[{w_next_idx, 3'b000} +: 8];
  assign w_req_base    = {reg_base_addr[5:0], 2'b00};
  // 1..4 map to 0..3 by wrap-around; 0 wraps to 3 and >4 is forced to 3.
  assign w_req_last    = (reg_byte_num > 4'd4) ? 2'd3 : (reg_byte_num[1:0] - 2'd1);
  assign w_unused_base = ^reg_base_addr[7:6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_idx       <= 2'd0;
      r_last      <= 2'd0;
      r_base      <= 8'd0;
      r_wvar      <= 32'd0;
      r_reg_rvar  <= 32'd0;
      r_res       <= 1'b0;
      r_busy      <= 1'b0;
      r_io_update <= 1'b0;
      r_p_wr      <= 1'b1;
      r_p_rd      <= 1'b1;
      r_p_addr    <= 8'd0;
      r_p_wdata   <= 8'd0;
      r_tri       <= 1'b0;
    end else begin
      if (!w_cnt_done) r_cnt <= r_cnt - 8'd1;
      case (r_state)
        ST_IDLE: if (load) begin
          r_base     <= w_req_base;
          r_wvar     <= reg_wvar;
          r_last     <= w_req_last;
          r_idx      <= 2'd0;
          r_res      <= 1'b0;
          r_reg_rvar <= 32'd0;
          r_busy     <= 1'b1;
          r_p_addr   <= w_req_base;
          r_p_wdata  <= reg_wvar[7:0];
          r_tri      <= 1'b1;
          r_cnt      <= c_setup;
          r_state    <= ST_W_SETUP;
        end
        ST_W_SETUP: if (w_cnt_done) begin
          r_p_wr  <= 1'b0;
          r_cnt   <= c_wr;
          r_state <= ST_W_STROBE;
        end
        ST_W_STROBE: if (w_cnt_done) begin
          r_p_wr  <= 1'b1;
          r_cnt   <= c_hold;
          r_state <= ST_W_HOLD;
        end
        ST_W_HOLD: if (w_cnt_done) begin
          if (w_is_last) begin
            r_io_update <= 1'b1;
            r_cnt       <= c_ioup;
            r_state     <= ST_IOUP;
          end else begin
            r_idx     <= w_next_idx;
            r_p_addr  <= r_base + {6'd0, w_next_idx};
            r_p_wdata <= w_next_byte;
            r_cnt     <= c_setup;
            r_state   <= ST_W_SETUP;
          end
        end
        ST_IOUP: if (w_cnt_done) begin
          r_io_update <= 1'b0;
          r_tri       <= 1'b0;
          if (VERIFY_EN) begin
            r_idx    <= 2'd0;
            r_p_addr <= r_base;
            r_cnt    <= c_setup;
            r_state  <= ST_R_SETUP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_R_SETUP: if (w_cnt_done) begin
          r_p_rd  <= 1'b0;
          r_cnt   <= c_rd;
          r_state <= ST_R_STROBE;
        end
        ST_R_STROBE: if (w_cnt_done) begin
          r_reg_rvar[{r_idx, 3'b000} +: 8] <= p_rdata;
          if (p_rdata != w_cur_byte) r_res <= 1'b1;
          r_p_rd  <= 1'b1;
          r_cnt   <= c_hold;
          r_state <= ST_R_HOLD;
        end
        ST_R_HOLD: if (w_cnt_done) begin
          if (w_is_last) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_idx    <= w_next_idx;
            r_p_addr <= r_base + {6'd0, w_next_idx};
            r_cnt    <= c_setup;
            r_state  <= ST_R_SETUP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reg_rvar        = r_reg_rvar;
  assign res             = r_res;
  assign busy            = r_busy;
  assign finish          = ~r_busy;
  assign io_update       = r_io_update;
  assign p_pwd           = 1'b0;
  assign p_wr            = r_p_wr;
  assign p_rd            = r_p_rd;
  assign p_addr          = r_p_addr;
  assign p_wdata         = r_p_wdata;
  assign data_tri_select = r_tri;

endmodule
`default_nettype wire
